gesture_stream_feeder: RTL and testbench
========================================

Name: gesture_stream_feeder

Overview:
- Producer side of the gesture-matching path: supplies the similarity engine with (vector, library) pairs.
- Keeps a ring history of the last FRAMES real-time motion vectors (60 fps) and a writable template library of TEMPLATES x FRAMES entries.
- On trigger, streams every template against the frozen history, oldest frame first, one pair per cycle.
- Also emits the start pulse and the template index the similarity engine consumes.

Parameters:
- FRAMES, 26, frames per gesture (history depth and template length)
- TEMPLATES, 16, number of library templates
- VW, 6, signed two's-complement width of each vector component

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_mv_valid  in  1  real-time motion vector strobe
- i_mv_x, i_mv_y  in  VW each  real-time motion vector
- i_trigger  in  1  request a match pass
- i_lib_we  in  1  library write enable
- i_lib_addr  in  9  library address, t*FRAMES+f
- i_lib_x, i_lib_y  in  VW each  library write data
- o_ready  out  1  IDLE and history full (FRAMES entries)
- o_busy  out  1  pass in progress (START/STREAM/DONE)
- o_valid  out  1  one-cycle pulse coincident with the first pair of a pass
- o_pair_valid  out  1  pair outputs valid this cycle
- o_index  out  4  template number t of the current pair
- o_vector_x, o_vector_y  out  VW each  history frame
- o_lib_x, o_lib_y  out  VW each  library entry
- o_done  out  1  one-cycle pulse after the last pair
- o_overflow  out  1  sticky: pending motion vector overwritten while busy

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, wr_ptr 0, fill 0, pending empty, o_overflow 0. Library and history RAM contents are not reset.

History writes:
- In IDLE, i_mv_valid writes history[wr_ptr]. wr_ptr wraps FRAMES-1 -> 0. fill saturates at FRAMES.
- While busy, a vector goes to a 1-entry pending register. If pending is already full, the new vector overwrites it and o_overflow is set.
- Pending commits to history in the DONE cycle.

Library writes:
- Accepted only in IDLE with i_lib_addr < FRAMES*TEMPLATES.
- Otherwise silently ignored.

States:
- IDLE -> START: i_trigger && fill==FRAMES, evaluated after any same-cycle history write. The concurrent vector is included as the newest frame. Trigger with fill<FRAMES is ignored.
- START (1 cycle): snapshot base = wr_ptr (post-write). Issue read for k=0.
- STREAM: k counts 0..FRAMES*TEMPLATES-1 (415).
  - t = k/FRAMES, f = k%FRAMES.
  - Vector read = history[(base+f) mod FRAMES]; library read = lib[t*FRAMES+f].
  - Outputs are registered, one cycle behind the read.
- DONE (1 cycle): o_done=1, commit pending, -> IDLE.

Timing (trigger accepted at edge N):
- o_busy=1 from N+1 through the DONE cycle.
- o_valid=1 and o_pair_valid=1 at N+2 with k=0.
- o_pair_valid stays high for exactly 416 consecutive cycles (N+2..N+417).
- o_done=1 at N+418. o_ready returns at N+419.

Other rules:
- o_index = t for the pair being presented. Counter widths cover 415 without wrap.
- i_trigger while busy is ignored; no queuing.
- o_overflow clears only on reset.

Test Plan:
- Fill: write 26 vectors x=y=f (f=0..25), then trigger -> o_valid at N+2, pair stream oldest first (0..25) repeated per template, o_index steps 0..15 every 26 cycles, o_done at N+418.
- Wrap: write 30 vectors (x=0..29), trigger -> history streams x=4..29 in order.
- Library: write lib[t*26+f] = (t, f-13) -> o_lib_x equals o_index and o_lib_y = f-13 (signed) for all 416 pairs. Writes to addr 416 and 511 have no effect.
- Busy: 2 motion vectors arrive during STREAM -> o_overflow=1. Only the second is committed at DONE. A trigger during STREAM produces no second pass.
- Edges: trigger with fill=25 -> no o_busy. Trigger in the same cycle as the 26th write -> accepted, the new vector is the last frame.
- Reset mid-STREAM (k=200) -> all outputs 0 immediately. o_ready stays 0 until 26 new writes.

Source files
------------

// File: rtl/gesture_stream_feeder.sv
// gesture_stream_feeder: motion-vector history ring plus template library,
// streamed as (history frame, library entry) pairs to the similarity engine.
module gesture_stream_feeder #(
    parameter int FRAMES    = 26,
    parameter int TEMPLATES = 16,
    parameter int VW        = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_mv_valid,
    input  logic [VW-1:0]                i_mv_x,
    input  logic [VW-1:0]                i_mv_y,
    input  logic                         i_trigger,
    input  logic                         i_lib_we,
    input  logic [8:0]                   i_lib_addr,
    input  logic [VW-1:0]                i_lib_x,
    input  logic [VW-1:0]                i_lib_y,
    output logic                         o_ready,
    output logic                         o_busy,
    output logic                         o_valid,
    output logic                         o_pair_valid,
    output logic [$clog2(TEMPLATES)-1:0] o_index,
    output logic [VW-1:0]                o_vector_x,
    output logic [VW-1:0]                o_vector_y,
    output logic [VW-1:0]                o_lib_x,
    output logic [VW-1:0]                o_lib_y,
    output logic                         o_done,
    output logic                         o_overflow
);
    localparam int FW = $clog2(FRAMES);
    localparam int TW = $clog2(TEMPLATES);
    localparam int NP = FRAMES * TEMPLATES;
    localparam int KW = $clog2(NP);
    localparam logic [FW:0] FULL = (FW+1)'(FRAMES);

    typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;

    state_t state_q, state_d;
    logic [FW-1:0] wr_ptr_q, wr_ptr_d, base_q, base_d, f_q, f_d, hist_ra;
    logic [FW:0] fill_q, fill_d, ra_sum;
    logic [TW-1:0] t_q, t_d;
    logic [KW-1:0] k_q, k_d;
    logic pend_full_q, pend_full_d, overflow_q, overflow_d;
    logic [VW-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic hist_we, lib_we, idle, commit, f_last, k_last;
    logic [VW-1:0] hist_wx, hist_wy;
    logic ready_d, busy_d, valid_d, pair_valid_d, done_d;
    logic [TW-1:0] index_d;
    logic [VW-1:0] vec_x_d, vec_y_d, lib_x_d, lib_y_d;
    logic [2*VW-1:0] hist_mem [FRAMES];
    logic [2*VW-1:0] lib_mem [NP];

    assign idle    = state_q == IDLE;
    assign commit  = pend_full_q && (idle || state_q == DONE);
    assign f_last  = f_q == FW'(FRAMES-1);
    assign k_last  = k_q == KW'(NP-1);
    assign lib_we  = idle && i_lib_we && (int'(i_lib_addr) < NP);
    assign ra_sum  = {1'b0, base_q} + {1'b0, f_q};
    assign hist_ra = ra_sum >= FULL ? FW'(ra_sum - FULL) : FW'(ra_sum);

    // A held vector drains ahead of any newer one so history order is preserved.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        pend_full_d = pend_full_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        overflow_d  = overflow_q;
        hist_we     = 1'b0;
        hist_wx     = commit ? pend_x_q : i_mv_x;
        hist_wy     = commit ? pend_y_q : i_mv_y;
        if (commit) begin
            hist_we     = 1'b1;
            pend_full_d = 1'b0;
        end else if (idle && i_mv_valid) begin
            hist_we = 1'b1;
        end
        if (i_mv_valid && (!idle || commit)) begin
            pend_full_d = 1'b1;
            pend_x_d    = i_mv_x;
            pend_y_d    = i_mv_y;
            overflow_d  = overflow_q | (pend_full_q & ~commit);
        end
        if (hist_we) begin
            wr_ptr_d = wr_ptr_q == FW'(FRAMES-1) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = fill_q == FULL ? fill_q : fill_q + 1'b1;
        end
    end

    always_comb begin
        base_d = state_q == START ? wr_ptr_q : base_q;
        k_d    = state_q == START ? '0 : state_q == STREAM ? k_q + 1'b1 : k_q;
        f_d    = state_q == START ? '0 : state_q == STREAM ? (f_last ? '0 : f_q + 1'b1) : f_q;
        t_d    = state_q == START ? '0 : state_q == STREAM && f_last ? t_q + 1'b1 : t_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_trigger && fill_d == FULL ? START : IDLE;
            START:   state_d = STREAM;
            STREAM:  state_d = k_last ? DONE : STREAM;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d      = idle && fill_q == FULL;
        busy_d       = !idle;
        pair_valid_d = state_q == STREAM;
        valid_d      = state_q == STREAM && k_q == '0;
        done_d       = state_q == DONE;
        index_d      = state_q == STREAM ? t_q : o_index;
        vec_x_d      = state_q == STREAM ? hist_mem[hist_ra][2*VW-1:VW] : o_vector_x;
        vec_y_d      = state_q == STREAM ? hist_mem[hist_ra][VW-1:0] : o_vector_y;
        lib_x_d      = state_q == STREAM ? lib_mem[k_q][2*VW-1:VW] : o_lib_x;
        lib_y_d      = state_q == STREAM ? lib_mem[k_q][VW-1:0] : o_lib_y;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            pend_full_q <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            overflow_q  <= 1'b0;
            base_q      <= '0;
            k_q         <= '0;
            f_q         <= '0;
            t_q         <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            pend_full_q <= pend_full_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            overflow_q  <= overflow_d;
            base_q      <= base_d;
            k_q         <= k_d;
            f_q         <= f_d;
            t_q         <= t_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready      <= 1'b0;
            o_busy       <= 1'b0;
            o_valid      <= 1'b0;
            o_pair_valid <= 1'b0;
            o_done       <= 1'b0;
            o_index      <= '0;
            o_vector_x   <= '0;
            o_vector_y   <= '0;
            o_lib_x      <= '0;
            o_lib_y      <= '0;
        end else begin
            o_ready      <= ready_d;
            o_busy       <= busy_d;
            o_valid      <= valid_d;
            o_pair_valid <= pair_valid_d;
            o_done       <= done_d;
            o_index      <= index_d;
            o_vector_x   <= vec_x_d;
            o_vector_y   <= vec_y_d;
            o_lib_x      <= lib_x_d;
            o_lib_y      <= lib_y_d;
        end
    end

    assign o_overflow = overflow_q;

    always_ff @(posedge i_clk) begin
        if (hist_we) hist_mem[wr_ptr_q] <= {hist_wx, hist_wy};
        if (lib_we)  lib_mem[i_lib_addr] <= {i_lib_x, i_lib_y};
    end
endmodule

// File: tb/tb_gesture_stream_feeder.sv
// tb_gesture_stream_feeder: random and directed passes checked against a
// queue-based model of the history ring and an array model of the library.
module tb_gesture_stream_feeder;
    localparam int FRAMES = 26;
    localparam int TEMPLATES = 16;
    localparam int VW = 6;
    localparam int NP = FRAMES * TEMPLATES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mv_valid = 1'b0, trigger = 1'b0, lib_we = 1'b0;
    logic [VW-1:0] mv_x = '0, mv_y = '0, lib_x = '0, lib_y = '0;
    logic [8:0] lib_addr = '0;
    logic ready, busy, valid, pair_valid, done, overflow;
    logic [3:0] index;
    logic [VW-1:0] vec_x, vec_y, o_lx, o_ly;

    always #5 clk = ~clk;

    gesture_stream_feeder #(.FRAMES(FRAMES), .TEMPLATES(TEMPLATES), .VW(VW)) dut (
        .i_clk(clk), .i_rst(rst), .i_mv_valid(mv_valid), .i_mv_x(mv_x), .i_mv_y(mv_y),
        .i_trigger(trigger), .i_lib_we(lib_we), .i_lib_addr(lib_addr),
        .i_lib_x(lib_x), .i_lib_y(lib_y), .o_ready(ready), .o_busy(busy),
        .o_valid(valid), .o_pair_valid(pair_valid), .o_index(index),
        .o_vector_x(vec_x), .o_vector_y(vec_y), .o_lib_x(o_lx), .o_lib_y(o_ly),
        .o_done(done), .o_overflow(overflow)
    );

    int n_cmp = 0, n_bad = 0;
    logic [VW-1:0] hx[$], hy[$];
    logic [VW-1:0] lx [NP];
    logic [VW-1:0] ly [NP];
    bit pend_v = 0, ovf = 0;
    logic [VW-1:0] pend_x, pend_y;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_hist(input logic [VW-1:0] x, input logic [VW-1:0] y);
        hx.push_back(x);
        hy.push_back(y);
        if (hx.size() > FRAMES) begin
            void'(hx.pop_front());
            void'(hy.pop_front());
        end
    endfunction

    task automatic lib_wr(input int a, input logic [VW-1:0] x, input logic [VW-1:0] y);
        lib_we = 1'b1;
        lib_addr = 9'(a);
        lib_x = x;
        lib_y = y;
        tick();
        lib_we = 1'b0;
        if (a < NP) begin
            lx[a] = x;
            ly[a] = y;
        end
    endtask

    task automatic mv_wr(input logic [VW-1:0] x, input logic [VW-1:0] y, input bit trig);
        mv_valid = 1'b1;
        mv_x = x;
        mv_y = y;
        trigger = trig;
        tick();
        mv_valid = 1'b0;
        trigger = 1'b0;
        push_hist(x, y);
    endtask

    task automatic trig_only();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ready"}, ready, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " valid"}, valid, 0);
        check({tag, " pair_valid"}, pair_valid, 0);
        check({tag, " done"}, done, 0);
        check({tag, " overflow"}, overflow, 0);
        check({tag, " index"}, index, 0);
        check({tag, " vec_x"}, vec_x, 0);
        check({tag, " lib_y"}, o_ly, 0);
    endtask

    // Called right after the trigger edge N; the model history is frozen here.
    task automatic stream_pass(input bit inject, input int rst_at);
        logic [VW-1:0] sx[$], sy[$];
        sx = hx;
        sy = hy;
        tick();
        check("busy N+1", busy, 1);
        check("pair_valid N+1", pair_valid, 0);
        check("ready N+1", ready, 0);
        for (int k = 0; k < NP; k++) begin
            int t = k / FRAMES;
            int f = k % FRAMES;
            int a = t * FRAMES + f;
            if (inject && (k == 50 || k == 100)) begin
                mv_valid = 1'b1;
                mv_x = VW'($urandom);
                mv_y = VW'($urandom);
                if (pend_v) ovf = 1;
                pend_v = 1;
                pend_x = mv_x;
                pend_y = mv_y;
            end
            if (inject && k == 150) trigger = 1'b1;
            tick();
            mv_valid = 1'b0;
            trigger = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_zero("reset mid-stream");
                tick();
                rst = 1'b0;
                hx.delete();
                hy.delete();
                pend_v = 0;
                ovf = 0;
                return;
            end
            check($sformatf("pair_valid k%0d", k), pair_valid, 1);
            check($sformatf("valid k%0d", k), valid, k == 0);
            check($sformatf("index k%0d", k), index, t);
            check($sformatf("vec_x k%0d", k), vec_x, sx[f]);
            check($sformatf("vec_y k%0d", k), vec_y, sy[f]);
            check($sformatf("lib_x k%0d", k), o_lx, lx[a]);
            check($sformatf("lib_y k%0d", k), o_ly, ly[a]);
            check($sformatf("done k%0d", k), done, 0);
        end
        tick();
        check("done N+418", done, 1);
        check("busy N+418", busy, 1);
        check("pair_valid N+418", pair_valid, 0);
        if (pend_v) push_hist(pend_x, pend_y);
        pend_v = 0;
        tick();
        check("ready N+419", ready, 1);
        check("busy N+419", busy, 0);
        check("done N+419", done, 0);
        check("overflow", overflow, ovf);
    endtask

    initial begin
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        for (int t = 0; t < TEMPLATES; t++)
            for (int f = 0; f < FRAMES; f++)
                lib_wr(t * FRAMES + f, VW'(t), VW'(f - 13));
        lib_wr(416, 6'h3f, 6'h3f);
        lib_wr(511, 6'h2a, 6'h15);
        for (int f = 0; f < FRAMES - 1; f++) mv_wr(VW'(f), VW'(f), 1'b0);
        check("ready fill25", ready, 0);
        trig_only();
        tick();
        check("busy trig fill25", busy, 0);
        mv_wr(VW'(25), VW'(25), 1'b1);
        stream_pass(1'b0, -1);
        for (int x = 26; x < 30; x++) mv_wr(VW'(x), VW'(x), 1'b0);
        trig_only();
        stream_pass(1'b0, -1);
        trig_only();
        stream_pass(1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no second pass", busy, 0);
        end
        for (int r = 0; r < 3; r++) begin
            int nl = $urandom_range(0, 40);
            int nm = $urandom_range(0, 40);
            for (int i = 0; i < nl; i++)
                lib_wr($urandom_range(0, 511), VW'($urandom), VW'($urandom));
            for (int i = 0; i < nm; i++) mv_wr(VW'($urandom), VW'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) mv_wr(VW'($urandom), VW'($urandom), 1'b1);
            else trig_only();
            stream_pass(1'b0, -1);
        end
        trig_only();
        stream_pass(1'b0, 200);
        check("overflow after reset", overflow, 0);
        for (int i = 0; i < FRAMES - 1; i++) mv_wr(VW'($urandom), VW'($urandom), 1'b0);
        check("ready 25 after reset", ready, 0);
        trig_only();
        tick();
        check("busy 25 after reset", busy, 0);
        mv_wr(VW'($urandom), VW'($urandom), 1'b0);
        tick();
        check("ready 26 after reset", ready, 1);
        trig_only();
        stream_pass(1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
